// File: rtl/debounce_arbiter_if.sv
// debounce_arbiter_if: raw switch pins and debounced switch outputs
interface debounce_arbiter_if #(parameter int NUM_SW = 4);
  logic [NUM_SW-1:0] i_Switch;
  logic [NUM_SW-1:0] o_Stable;
  logic [NUM_SW-1:0] o_Release_Pulse;
  logic [NUM_SW-1:0] o_LED;
  logic              o_Busy;
  modport master (output i_Switch, input o_Stable, o_Release_Pulse, o_LED, o_Busy);
  modport slave  (input i_Switch, output o_Stable, o_Release_Pulse, o_LED, o_Busy);
endinterface

// File: rtl/debounce_arbiter.sv
// debounce_arbiter: one shared debounce counter granted round-robin to switches whose level disagrees
module debounce_arbiter #(
  parameter int NUM_SW         = 4,
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input logic                i_Clk,
  input logic                i_Rst_L,
  debounce_arbiter_if.slave  sw
);
  localparam int CW = $clog2(DEBOUNCE_LIMIT);
  localparam int PW = $clog2(NUM_SW);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] COUNT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  logic [NUM_SW-1:0] meta, sync, mismatch;
  logic [NUM_SW-1:0] stable_q, pulse_q, led_q;
  logic              busy_q;
  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     ptr, grant, pick, grant_next;
  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v >= NUM_SW ? v - NUM_SW : v);
  endfunction
  assign mismatch   = sync ^ stable_q;
  assign grant_next = wrap(int'(grant) + 1);
  // scan downwards so the channel closest to the pointer is the last one written
  always_comb begin
    pick = ptr;
    for (int k = NUM_SW - 1; k >= 0; k--)
      if (mismatch[wrap(int'(ptr) + k)]) pick = wrap(int'(ptr) + k);
  end
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta     <= '0;
      sync     <= '0;
      stable_q <= '0;
      pulse_q  <= '0;
      led_q    <= '0;
      busy_q   <= 1'b0;
      cnt      <= '0;
      ptr      <= '0;
      grant    <= '0;
      state    <= IDLE;
    end else begin
      meta    <= sw.i_Switch;
      sync    <= meta;
      pulse_q <= '0;
      case (state)
        IDLE: if (|mismatch) begin
          grant  <= pick;
          cnt    <= '0;
          busy_q <= 1'b1;
          state  <= COUNT;
        end
        COUNT: if (!mismatch[grant]) begin
          ptr    <= grant_next;
          busy_q <= 1'b0;
          state  <= IDLE;
        end else if (cnt == CW'(DEBOUNCE_LIMIT - 1)) begin
          state <= COMMIT;
        end else begin
          cnt <= cnt + 1'b1;
        end
        COMMIT: begin
          stable_q[grant] <= ~stable_q[grant];
          pulse_q[grant]  <= stable_q[grant];
          led_q[grant]    <= led_q[grant] ^ stable_q[grant];
          ptr             <= grant_next;
          busy_q          <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign sw.o_Stable        = stable_q;
  assign sw.o_Release_Pulse = pulse_q;
  assign sw.o_LED           = led_q;
  assign sw.o_Busy          = busy_q;
endmodule

// File: tb/tb_debounce_arbiter.sv
// tb_debounce_arbiter: directed switch scenarios checked against a countdown-based reference model
module tb_debounce_arbiter;
  localparam int N = 4;
  localparam int L = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int p1 = 0;
  debounce_arbiter_if #(.NUM_SW(N)) sw ();
  debounce_arbiter #(.NUM_SW(N), .DEBOUNCE_LIMIT(L)) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .sw      (sw.slave)
  );
  always #5 clk = ~clk;
  logic [N-1:0] m_s1, m_s2, m_stab, m_led, m_pulse;
  int m_owner, m_left, m_ptr, j;
  // a job owns the counter for L+1 edges after its grant unless its input reverts first
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_led = '0; m_pulse = '0;
      m_owner = -1; m_left = 0; m_ptr = 0;
    end else begin
      m_pulse = '0;
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (m_owner < 0 && m_s2[j] != m_stab[j]) m_owner = j;
        end
        m_left = L + 1;
      end else if (m_left == 1) begin
        if (m_stab[m_owner]) begin
          m_pulse[m_owner] = 1'b1;
          m_led[m_owner] = ~m_led[m_owner];
        end
        m_stab[m_owner] = ~m_stab[m_owner];
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end else if (m_s2[m_owner] == m_stab[m_owner]) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_left--;
      end
      m_s2 = m_s1;
      m_s1 = sw.i_Switch;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    chk("model_stable", 32'(sw.o_Stable), 32'(m_stab));
    chk("model_pulse", 32'(sw.o_Release_Pulse), 32'(m_pulse));
    chk("model_led", 32'(sw.o_LED), 32'(m_led));
    chk("model_busy", 32'(sw.o_Busy), 32'(m_owner >= 0));
    if (sw.o_Release_Pulse[1]) p1++;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    tick(1);
    #2 rst_n = 1'b1;
    tick(1);
  endtask
  logic [N-1:0] led1_exp;
  initial begin
    sw.i_Switch = '0;
    led1_exp = 4'b0101;
    tick(2);
    chk("rst_stable", 32'(sw.o_Stable), 0);
    chk("rst_pulse", 32'(sw.o_Release_Pulse), 0);
    chk("rst_led", 32'(sw.o_LED), 0);
    chk("rst_busy", 32'(sw.o_Busy), 0);
    #2 rst_n = 1'b1;
    tick(1);
    sw.i_Switch = 4'b0001;
    tick(11);
    chk("press_before", 32'(sw.o_Stable), 0);
    chk("press_busy", 32'(sw.o_Busy), 1);
    tick(1);
    chk("press_at_T12", 32'(sw.o_Stable), 4'b0001);
    chk("press_no_led", 32'(sw.o_LED), 0);
    tick(28);
    sw.i_Switch = 4'b0000;
    tick(11);
    chk("rel_before", 32'(sw.o_Stable), 4'b0001);
    tick(1);
    chk("rel_stable", 32'(sw.o_Stable), 0);
    chk("rel_pulse", 32'(sw.o_Release_Pulse), 4'b0001);
    chk("rel_led", 32'(sw.o_LED), 4'b0001);
    tick(1);
    chk("rel_pulse_1cyc", 32'(sw.o_Release_Pulse), 0);
    sw.i_Switch = 4'b0010;
    tick(5);
    chk("glitch_busy", 32'(sw.o_Busy), 1);
    sw.i_Switch = 4'b0000;
    tick(6);
    chk("glitch_idle", 32'(sw.o_Busy), 0);
    chk("glitch_stable", 32'(sw.o_Stable), 0);
    chk("glitch_led", 32'(sw.o_LED), 4'b0001);
    pulse_reset();
    sw.i_Switch = 4'b1111;
    tick(12);
    chk("simul_0", 32'(sw.o_Stable), 4'b0001);
    tick(9);
    chk("simul_gap", 32'(sw.o_Stable), 4'b0001);
    tick(1);
    chk("simul_1", 32'(sw.o_Stable), 4'b0011);
    tick(10);
    chk("simul_2", 32'(sw.o_Stable), 4'b0111);
    tick(10);
    chk("simul_3", 32'(sw.o_Stable), 4'b1111);
    sw.i_Switch = 4'b0000;
    tick(45);
    chk("simul_rel_stable", 32'(sw.o_Stable), 0);
    chk("simul_rel_led", 32'(sw.o_LED), 4'b1111);
    sw.i_Switch = 4'b0100;
    tick(12);
    chk("wrap_setup", 32'(sw.o_Stable), 4'b0100);
    sw.i_Switch = 4'b1101;
    tick(12);
    chk("wrap_ch3_first", 32'(sw.o_Stable), 4'b1100);
    tick(10);
    chk("wrap_ch0_next", 32'(sw.o_Stable), 4'b1101);
    sw.i_Switch = 4'b0000;
    tick(35);
    chk("wrap_rel_led", 32'(sw.o_LED), 4'b0010);
    sw.i_Switch = 4'b0100;
    tick(8);
    chk("midcnt_busy", 32'(sw.o_Busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_stable", 32'(sw.o_Stable), 0);
    chk("async_led", 32'(sw.o_LED), 0);
    chk("async_busy", 32'(sw.o_Busy), 0);
    tick(2);
    #2 rst_n = 1'b1;
    tick(11);
    chk("rerun_before", 32'(sw.o_Stable), 0);
    tick(1);
    chk("rerun_stable", 32'(sw.o_Stable), 4'b0100);
    sw.i_Switch = 4'b0000;
    tick(12);
    chk("ch2_rel_pulse", 32'(sw.o_Release_Pulse), 4'b0100);
    p1 = 0;
    for (int i = 0; i < 3; i++) begin
      sw.i_Switch = 4'b0010;
      tick(14);
      sw.i_Switch = 4'b0000;
      tick(12);
      chk("led_pulse", 32'(sw.o_Release_Pulse), 4'b0010);
      chk("led_ch1", 32'(sw.o_LED[1]), 32'(led1_exp[i]));
    end
    tick(3);
    chk("led_pulse_count", 32'(p1), 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
